fpu: RTL and testbench



---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_round.sv | 44 ++++
 rtl/fpu.sv | 207 ++++++++++++++++++++
 tb/tb_fpu.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/fpu_round.sv
// Normalize, round-to-nearest-even and range-check one binary32 result.
// man[26] is the hidden-bit position for exponent exp; man[2:0] are G/R/S.
module fpu_round
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp,
    input  logic [26:0]       man,
    output logic [31:0]       result
);

    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] e_n;
    logic signed [9:0] e_r;
    logic              up;
    logic              carry;
    logic [22:0]       frac;

    // Leading-zero normalize, RNE rounding, then overflow/underflow clamp
    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (man[i]) lz = 5'(26 - i);
        end
        norm = man << lz;
        e_n  = exp - 10'(lz);
        up   = norm[2] & (norm[3] | norm[1] | norm[0]);
        // A carry out of the fraction means 1.111..1 rounded to 10.000..0
        {carry, frac} = {1'b0, norm[25:3]} + 24'(up);
        e_r  = e_n + 10'(carry);

        if (!norm[26]) begin
            result = {sign, 31'b0};
        end else if (e_r >= 10'sd255) begin
            result = {sign, POS_INF[30:0]};
        end else if (e_r <= 10'sd0) begin
            result = {sign, 31'b0};
        end else begin
            result = {sign, e_r[7:0], frac};
        end
    end

endmodule

// File: rtl/fpu.sv
// Combinational binary32 add/sub/mul/div with a registered finish flag.
// Build option: define FPU_DIV_EN to include the divider; otherwise
// divide returns a quiet NaN.
module fpu
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] o,
    output logic        finish
);

    fp32_t   fa, fb;
    fpu_op_e op;
    logic    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic    sb_eff;
    logic [23:0] ma, mb;

    assign fa     = a;
    assign fb     = b;
    assign op     = fpu_op_e'(funct);
    assign a_zero = (fa.exp == '0);
    assign b_zero = (fb.exp == '0);
    assign a_inf  = (fa.exp == '1) && (fa.man == '0);
    assign b_inf  = (fb.exp == '1) && (fb.man == '0);
    assign a_nan  = (fa.exp == '1) && (fa.man != '0);
    assign b_nan  = (fb.exp == '1) && (fb.man != '0);
    assign sb_eff = fb.sign ^ (op == OP_SUB);
    // Subnormals are flushed by dropping the mantissa when exp is zero
    assign ma     = a_zero ? '0 : {1'b1, fa.man};
    assign mb     = b_zero ? '0 : {1'b1, fb.man};

    logic              a_big;
    logic [7:0]        e_big, e_sml, d;
    logic [23:0]       m_big, m_sml;
    logic [5:0]        shamt;
    logic [49:0]       ext;
    logic [26:0]       m_sml27, m_big27;
    logic [27:0]       sum;
    logic              add_sign;
    logic signed [9:0] add_exp;
    logic [26:0]       add_man;

    // Add/sub: order by magnitude, align, add or subtract magnitudes
    always_comb begin
        a_big   = {fa.exp, ma} >= {fb.exp, mb};
        e_big   = a_big ? fa.exp : fb.exp;
        e_sml   = a_big ? fb.exp : fa.exp;
        m_big   = a_big ? ma : mb;
        m_sml   = a_big ? mb : ma;
        d       = e_big - e_sml;
        // Beyond 27 positions every bit of the small operand lands in sticky
        shamt   = (d > 8'd27) ? 6'd27 : d[5:0];
        ext     = {m_sml, 26'b0} >> shamt;
        m_sml27 = {ext[49:24], |ext[23:0]};
        m_big27 = {m_big, 3'b000};
        add_sign = a_big ? fa.sign : sb_eff;
        if (fa.sign == sb_eff) begin
            sum = {1'b0, m_big27} + {1'b0, m_sml27};
            if (sum[27]) begin
                add_man = {sum[27:2], |sum[1:0]};
            end else begin
                add_man = sum[26:0];
            end
            add_exp = {2'b00, e_big} + 10'(sum[27]);
        end else begin
            sum     = {1'b0, m_big27 - m_sml27};
            add_man = sum[26:0];
            add_exp = {2'b00, e_big};
            // Exact cancellation yields +0
            if (sum == '0) add_sign = 1'b0;
        end
    end

    logic [47:0]       mul_p;
    logic              mul_sign;
    logic signed [9:0] mul_exp;
    logic [26:0]       mul_man;

    assign mul_p    = 48'(ma) * 48'(mb);
    assign mul_sign = fa.sign ^ fb.sign;
    // Exponent assumes a product in [2,4); the rounder shifts left once if not
    assign mul_exp  = {2'b00, fa.exp} + {2'b00, fb.exp} - 10'sd126;
    assign mul_man  = {mul_p[47:22], |mul_p[21:0]};

`ifdef FPU_DIV_EN
    logic [25:0]       rem;
    logic [25:0]       q;
    logic              div_sign;
    logic signed [9:0] div_exp;
    logic [26:0]       div_man;

    assign div_sign = fa.sign ^ fb.sign;
    assign div_exp  = {2'b00, fa.exp} - {2'b00, fb.exp} + 10'sd127;

    // Restoring division: 26 quotient bits, remainder folded into sticky
    always_comb begin
        rem = {2'b00, ma};
        q   = '0;
        for (int unsigned i = 0; i < 26; i++) begin
            if (rem >= {2'b00, mb}) begin
                q   = {q[24:0], 1'b1};
                rem = rem - {2'b00, mb};
            end else begin
                q   = {q[24:0], 1'b0};
            end
            rem = {rem[24:0], 1'b0};
        end
        div_man = {q, |rem};
    end
`endif

    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [26:0]       r_man;
    logic [31:0]       rnd_out;
    logic              special;
    logic [31:0]       spec_val;
    logic [31:0]       res;

    // Route the selected datapath into the shared rounder
    always_comb begin
        r_sign = add_sign;
        r_exp  = add_exp;
        r_man  = add_man;
        if (op == OP_MUL) begin
            r_sign = mul_sign;
            r_exp  = mul_exp;
            r_man  = mul_man;
        end
`ifdef FPU_DIV_EN
        if (op == OP_DIV) begin
            r_sign = div_sign;
            r_exp  = div_exp;
            r_man  = div_man;
        end
`endif
    end

    fpu_round u_round (
        .sign   (r_sign),
        .exp    (r_exp),
        .man    (r_man),
        .result (rnd_out)
    );

    // Special operands override the arithmetic result
    always_comb begin
        special  = 1'b0;
        spec_val = QNAN;
        case (op)
            OP_ADD, OP_SUB: begin
                if (a_inf && b_inf && (fa.sign != sb_eff)) begin
                    special = 1'b1;
                end else if (a_inf) begin
                    special  = 1'b1;
                    spec_val = {fa.sign, POS_INF[30:0]};
                end else if (b_inf) begin
                    special  = 1'b1;
                    spec_val = {sb_eff, POS_INF[30:0]};
                end
            end
            OP_MUL: begin
                if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                    special = 1'b1;
                end else if (a_inf || b_inf) begin
                    special  = 1'b1;
                    spec_val = {mul_sign, POS_INF[30:0]};
                end else if (a_zero || b_zero) begin
                    special  = 1'b1;
                    spec_val = {mul_sign, 31'b0};
                end
            end
            OP_DIV: begin
`ifdef FPU_DIV_EN
                if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                    special = 1'b1;
                end else if (b_zero || a_inf) begin
                    special  = 1'b1;
                    spec_val = {div_sign, POS_INF[30:0]};
                end else if (b_inf || a_zero) begin
                    special  = 1'b1;
                    spec_val = {div_sign, 31'b0};
                end
`else
                special = 1'b1;
`endif
            end
        endcase
        if (a_nan || b_nan) begin
            special  = 1'b1;
            spec_val = QNAN;
        end
        res = special ? spec_val : rnd_out;
        o   = rst_n ? res : '0;
    end

    // finish rises on the first clock after reset release and then holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) finish <= 1'b0;
        else        finish <= 1'b1;
    end

endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for fpu; divide vectors follow FPU_DIV_EN.
module tb_fpu;

    logic        clk;
    logic        rst_n;
    logic [1:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic        finish;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fpu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .funct  (funct),
        .a      (a),
        .b      (b),
        .o      (o),
        .finish (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive just after a rising edge, sample at the following falling edge
    task automatic run(input string tag, input logic [1:0] f,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp);
        @(posedge clk);
        #1;
        funct = f;
        a     = x;
        b     = y;
        @(negedge clk);
        check_eq(tag, o, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        funct = 2'b00;
        a     = 32'h3F800000;
        b     = 32'h3F800000;
        #3;
        check_eq("rst_o", o, 32'h0);
        check_eq("rst_finish", {31'b0, finish}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_o_clk", o, 32'h0);
        check_eq("rst_finish_clk", {31'b0, finish}, 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_o", o, 32'h40000000);
        check_eq("rel_finish_pre", {31'b0, finish}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rel_finish_post", {31'b0, finish}, 32'h1);

        run("add_basic",   2'b00, 32'h3FC00000, 32'h40100000, 32'h40700000);
        run("sub_basic",   2'b01, 32'h40A00000, 32'h40400000, 32'h40000000);
        run("sub_equal",   2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000);
        run("mul_basic",   2'b10, 32'h40400000, 32'hC0000000, 32'hC0C00000);
        run("mul_ovf",     2'b10, 32'h7F000000, 32'h40000000, 32'h7F800000);
        run("mul_sq",      2'b10, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
        run("mul_unf",     2'b10, 32'h00800000, 32'h3F000000, 32'h00000000);
        run("add_carry",   2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000);
        run("sub_negb",    2'b01, 32'h3F800000, 32'hBF800000, 32'h40000000);
        run("sub_cancel",  2'b01, 32'h40000000, 32'h3FFFFFFF, 32'h34000000);
        run("add_tie",     2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000);
        run("add_rnd_up",  2'b00, 32'h3F800000, 32'h34400000, 32'h3F800002);
        run("add_negzero", 2'b00, 32'h80000000, 32'h80000000, 32'h80000000);
        run("add_mixzero", 2'b00, 32'h80000000, 32'h00000000, 32'h00000000);
        run("add_subnorm", 2'b00, 32'h00000001, 32'h00000000, 32'h00000000);
        run("add_nan",     2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
        run("sub_infinf",  2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000);
        run("add_inf",     2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000);
        run("sub_ninf",    2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000);
        run("mul_0inf",    2'b10, 32'h00000000, 32'hFF800000, 32'h7FC00000);
        run("mul_infneg",  2'b10, 32'h7F800000, 32'hC0000000, 32'hFF800000);
`ifdef FPU_DIV_EN
        run("div_basic",   2'b11, 32'h3F800000, 32'h40800000, 32'h3E800000);
        run("div_third",   2'b11, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
        run("div_by0",     2'b11, 32'h3F800000, 32'h00000000, 32'h7F800000);
        run("div_nby0",    2'b11, 32'hBF800000, 32'h00000000, 32'hFF800000);
        run("div_0by0",    2'b11, 32'h00000000, 32'h00000000, 32'h7FC00000);
`else
        run("div_off_a",   2'b11, 32'h40400000, 32'h3F800000, 32'h7FC00000);
        run("div_off_b",   2'b11, 32'h00000000, 32'h00000000, 32'h7FC00000);
        run("div_off_c",   2'b11, 32'h3F800000, 32'h40800000, 32'h7FC00000);
`endif
        run("add_after",   2'b00, 32'h3FC00000, 32'h40100000, 32'h40700000);

        // Reset asserted mid-operation gates o and clears finish at once
        @(posedge clk);
        #1;
        funct = 2'b10;
        a     = 32'h40400000;
        b     = 32'h40400000;
        #1;
        check_eq("mid_o_pre", o, 32'h41100000);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_o", o, 32'h0);
        check_eq("mid_rst_finish", {31'b0, finish}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rel_finish", {31'b0, finish}, 32'h1);
        check_eq("mid_rel_o", o, 32'h41100000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
